// File: rtl/dsp_sys_collect_pkg.sv
// dsp_pkg: shared types and helpers for the systolic-array output collector.
// Also supplies fallback values for the array geometry macros.
`ifndef HW_DSP_PE_COLS
`define HW_DSP_PE_COLS 4
`endif
`ifndef HW_DSP_VER_BUS_DW
`define HW_DSP_VER_BUS_DW 16
`endif

package dsp_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      ACC  = 1'b1
   } acc_state_e;

   localparam int MAX_DW = 64;

   // Extra wrap bit separates full from empty.
   function automatic int fifo_ptr_w(input int depth);
      return $clog2(depth) + 1;
   endfunction

   function automatic logic [MAX_DW-1:0] sat_max(input int dw);
      logic [MAX_DW-1:0] v;
      v = '0;
      for (int i = 0; i < dw - 1; i++) v[i] = 1'b1;
      return v;
   endfunction

   function automatic logic [MAX_DW-1:0] sat_min(input int dw);
      logic [MAX_DW-1:0] v;
      v = '0;
      v[dw-1] = 1'b1;
      return v;
   endfunction

endpackage

// File: rtl/dsp_sys_collect_fifo.sv
// First-word-fall-through FIFO with reset storage, occupancy count and a
// drop strobe for pushes that find it full with no simultaneous pop.
module dsp_sys_collect_fifo
   import dsp_pkg::*;
#(
   parameter int DW    = 32,
   parameter int DEPTH = 16,
   localparam int PW   = fifo_ptr_w(DEPTH)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          push,
   input  logic [DW-1:0] wdata,
   input  logic          pop,
   output logic [DW-1:0] rdata,
   output logic          empty,
   output logic [PW-1:0] count,
   output logic          drop
);

   localparam int AW = PW - 1;

   logic [DW-1:0] mem_q [DEPTH];
   logic [PW-1:0] wr_q, wr_d;
   logic [PW-1:0] rd_q, rd_d;
   logic          full;
   logic          pop_ok;
   logic          push_ok;

   always_comb begin
      empty   = (wr_q == rd_q);
      full    = (wr_q[AW] != rd_q[AW]) &&
                (wr_q[AW-1:0] == rd_q[AW-1:0]);
      pop_ok  = pop && !empty;
      push_ok = push && (!full || pop_ok);
      drop    = push && full && !pop_ok;
      wr_d    = wr_q + PW'(push_ok);
      rd_d    = rd_q + PW'(pop_ok);
      count   = wr_q - rd_q;
      rdata   = mem_q[rd_q[AW-1:0]];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_q <= '0;
         rd_q <= '0;
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else begin
         wr_q <= wr_d;
         rd_q <= rd_d;
         if (push_ok) mem_q[wr_q[AW-1:0]] <= wdata;
      end
   end

endmodule

// File: rtl/dsp_sys_collect.sv
// Deskews array bottom-edge psums, accumulates groups of rows, and queues
// the results. Define DSP_SYS_COLLECT_SAT_EN for saturating column sums.
`ifndef HW_DSP_PE_COLS
`define HW_DSP_PE_COLS 4
`endif
`ifndef HW_DSP_VER_BUS_DW
`define HW_DSP_VER_BUS_DW 16
`endif

module dsp_sys_collect
   import dsp_pkg::*;
#(
   parameter int COLS       = `HW_DSP_PE_COLS,
   parameter int VER_BUS_DW = `HW_DSP_VER_BUS_DW,
   parameter int ACC_DW     = 32,
   parameter int DEPTH      = 16,
   parameter int LEN_W      = 8
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic [COLS-1:0][VER_BUS_DW-1:0]  psu_in,
   input  logic                             psu_vld,
   input  logic [LEN_W-1:0]                 acc_len,
   output logic [COLS-1:0][ACC_DW-1:0]      out_data,
   output logic                             out_vld,
   input  logic                             out_rdy,
   output logic                             stall_req,
   output logic                             ovf_err
);

   localparam int PW = fifo_ptr_w(DEPTH);
   localparam int SD = COLS - 1;
   localparam logic [LEN_W-1:0] ONE = LEN_W'(1);

   typedef logic [COLS-1:0][ACC_DW-1:0] row_t;

   logic [COLS-1:0][VER_BUS_DW-1:0] aln;
   logic [SD-1:0]                   vld_q, vld_d;
   logic [SD-1:0][LEN_W-1:0]        lenp_q, lenp_d;
   logic                            aln_vld;
   logic [LEN_W-1:0]                aln_len;

   // Column c waits COLS-1-c cycles so all columns line up.
   for (genvar c = 0; c < COLS; c++) begin : g_col
      if (c == COLS - 1) begin : g_thru
         assign aln[c] = psu_in[c];
      end else begin : g_dly
         localparam int N = COLS - 1 - c;
         logic [VER_BUS_DW-1:0] sh_q [N];
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               for (int i = 0; i < N; i++) sh_q[i] <= '0;
            end else begin
               sh_q[0] <= psu_in[c];
               for (int i = 1; i < N; i++) sh_q[i] <= sh_q[i-1];
            end
         end
         assign aln[c] = sh_q[N-1];
      end
   end

   // Group length travels with the valid so it is sampled per vector.
   always_comb begin
      vld_d     = vld_q;
      lenp_d    = lenp_q;
      vld_d[0]  = psu_vld;
      lenp_d[0] = acc_len;
      for (int i = 1; i < SD; i++) begin
         vld_d[i]  = vld_q[i-1];
         lenp_d[i] = lenp_q[i-1];
      end
      aln_vld = vld_q[SD-1];
      aln_len = lenp_q[SD-1];
   end

   row_t       ext;
   row_t       add;
   row_t       acc_q, acc_d;
   acc_state_e st_q, st_d;
   logic [LEN_W-1:0] cnt_q, cnt_d;
   logic [LEN_W-1:0] len_q, len_d;
   logic       push_q, push_d;
   logic       ovf_q, ovf_d;

`ifdef DSP_SYS_COLLECT_SAT_EN
   localparam logic [MAX_DW-1:0] SMAX_W = sat_max(ACC_DW);
   localparam logic [MAX_DW-1:0] SMIN_W = sat_min(ACC_DW);
   localparam logic [ACC_DW-1:0] SMAX   = SMAX_W[ACC_DW-1:0];
   localparam logic [ACC_DW-1:0] SMIN   = SMIN_W[ACC_DW-1:0];
   logic [COLS-1:0] sat_q, sat_d;
   logic [COLS-1:0] add_sat;
`endif

   always_comb begin
      ext = '0;
      add = '0;
`ifdef DSP_SYS_COLLECT_SAT_EN
      add_sat = sat_q;
`endif
      for (int c = 0; c < COLS; c++) begin
         ext[c] = ACC_DW'($signed(aln[c]));
         add[c] = acc_q[c] + ext[c];
`ifdef DSP_SYS_COLLECT_SAT_EN
         if (sat_q[c]) begin
            add[c] = acc_q[c];
         end else if ((acc_q[c][ACC_DW-1] == ext[c][ACC_DW-1]) &&
                      (add[c][ACC_DW-1] != acc_q[c][ACC_DW-1])) begin
            add[c]     = acc_q[c][ACC_DW-1] ? SMIN : SMAX;
            add_sat[c] = 1'b1;
         end
`endif
      end
   end

   always_comb begin
      st_d   = st_q;
      acc_d  = acc_q;
      cnt_d  = cnt_q;
      len_d  = len_q;
      push_d = 1'b0;
`ifdef DSP_SYS_COLLECT_SAT_EN
      sat_d  = sat_q;
`endif
      if (aln_vld) begin
         unique case (st_q)
            IDLE: begin
               acc_d = ext;
               cnt_d = ONE;
               len_d = (aln_len == '0) ? ONE : aln_len;
`ifdef DSP_SYS_COLLECT_SAT_EN
               sat_d = '0;
`endif
               if (len_d == ONE) push_d = 1'b1;
               else              st_d   = ACC;
            end
            ACC: begin
               acc_d = add;
               cnt_d = cnt_q + ONE;
`ifdef DSP_SYS_COLLECT_SAT_EN
               sat_d = add_sat;
`endif
               if (cnt_d == len_q) begin
                  push_d = 1'b1;
                  st_d   = IDLE;
               end
            end
            default: st_d = IDLE;
         endcase
      end
   end

   logic [PW-1:0] count;
   logic          fifo_empty;
   logic          drop;
   int            occ;

   always_comb begin
      ovf_d     = ovf_q | drop;
      occ       = int'(count) + $countones(vld_q) + int'(push_q);
      stall_req = (occ >= DEPTH - 1);
      out_vld   = !fifo_empty;
      ovf_err   = ovf_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_q  <= '0;
         lenp_q <= '0;
         st_q   <= IDLE;
         acc_q  <= '0;
         cnt_q  <= '0;
         len_q  <= '0;
         push_q <= 1'b0;
         ovf_q  <= 1'b0;
`ifdef DSP_SYS_COLLECT_SAT_EN
         sat_q  <= '0;
`endif
      end else begin
         vld_q  <= vld_d;
         lenp_q <= lenp_d;
         st_q   <= st_d;
         acc_q  <= acc_d;
         cnt_q  <= cnt_d;
         len_q  <= len_d;
         push_q <= push_d;
         ovf_q  <= ovf_d;
`ifdef DSP_SYS_COLLECT_SAT_EN
         sat_q  <= sat_d;
`endif
      end
   end

   dsp_sys_collect_fifo #(
      .DW    (COLS * ACC_DW),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push_q),
      .wdata (acc_q),
      .pop   (out_rdy),
      .rdata (out_data),
      .empty (fifo_empty),
      .count (count),
      .drop  (drop)
   );

endmodule

// File: tb/tb_dsp_sys_collect.sv
// Bench for dsp_sys_collect: directed scenarios plus a random phase checked
// against a group-sum reference model and an expected-result queue.
`timescale 1ns/1ps
module tb_dsp_sys_collect;

   localparam int COLS  = 4;
   localparam int VDW   = 16;
   localparam int ADW   = 24;
   localparam int WDW   = 16;
   localparam int DEPTH = 8;
   localparam int LW    = 8;
   localparam longint AMAX = (longint'(1) << (ADW - 1)) - 1;
   localparam longint AMIN = -(longint'(1) << (ADW - 1));

   typedef logic [COLS-1:0][VDW-1:0] ivec_t;
   typedef logic [COLS-1:0][ADW-1:0] ovec_t;
   typedef logic [COLS-1:0][WDW-1:0] wvec_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   ivec_t          psu_in = '0;
   logic           psu_vld = 1'b0;
   logic [LW-1:0]  acc_len = 8'd1;
   ovec_t          out_data;
   logic           out_vld;
   logic           out_rdy = 1'b0;
   logic           stall_req;
   logic           ovf_err;
   wvec_t          w_data;
   logic           w_vld;
   logic           w_rdy = 1'b0;
   logic           w_stall;
   logic           w_ovf;

   dsp_sys_collect #(
      .COLS(COLS), .VER_BUS_DW(VDW), .ACC_DW(ADW), .DEPTH(DEPTH), .LEN_W(LW)
   ) dut (
      .clk(clk), .rst_n(rst_n), .psu_in(psu_in), .psu_vld(psu_vld),
      .acc_len(acc_len), .out_data(out_data), .out_vld(out_vld),
      .out_rdy(out_rdy), .stall_req(stall_req), .ovf_err(ovf_err)
   );

   dsp_sys_collect #(
      .COLS(COLS), .VER_BUS_DW(VDW), .ACC_DW(WDW), .DEPTH(DEPTH), .LEN_W(LW)
   ) dut_w (
      .clk(clk), .rst_n(rst_n), .psu_in(psu_in), .psu_vld(psu_vld),
      .acc_len(acc_len), .out_data(w_data), .out_vld(w_vld),
      .out_rdy(w_rdy), .stall_req(w_stall), .ovf_err(w_ovf)
   );

   int     n_vec = 0;
   int     n_err = 0;
   int     n_pop = 0;
   ovec_t  expq[$];
   ovec_t  mon_e;
   ivec_t  hist [COLS];
   int     g_cnt = 0;
   int     g_len = 1;
   longint g_sum [COLS];
   bit     g_sat [COLS];

   task automatic chk(input string tag, input logic [127:0] got,
                      input logic [127:0] exp);
      n_vec++;
      assert (got === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   // Reference: a group is len vectors; column sums of sign-extended psums.
   task automatic model_vec(input ivec_t v, input int len);
      ovec_t  o;
      longint s;
      if (g_cnt == 0) begin
         g_len = (len == 0) ? 1 : len;
         for (int c = 0; c < COLS; c++) begin
            g_sum[c] = longint'($signed(v[c]));
            g_sat[c] = 1'b0;
         end
      end else begin
         for (int c = 0; c < COLS; c++) begin
            if (!g_sat[c]) begin
               s = g_sum[c] + longint'($signed(v[c]));
`ifdef DSP_SYS_COLLECT_SAT_EN
               if (s > AMAX) begin s = AMAX; g_sat[c] = 1'b1; end
               if (s < AMIN) begin s = AMIN; g_sat[c] = 1'b1; end
`endif
               g_sum[c] = s;
            end
         end
      end
      g_cnt++;
      if (g_cnt == g_len) begin
         for (int c = 0; c < COLS; c++) o[c] = ADW'(g_sum[c]);
         expq.push_back(o);
         g_cnt = 0;
      end
   endtask

   // Column c carries the vector issued c cycles earlier.
   task automatic drive(input bit v, input ivec_t d);
      for (int k = COLS - 1; k > 0; k--) hist[k] = hist[k-1];
      hist[0] = v ? d : '0;
      for (int c = 0; c < COLS; c++) psu_in[c] = hist[c][c];
      psu_vld = v;
      if (v) model_vec(d, int'(acc_len));
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      repeat (n) drive(1'b0, '0);
   endtask

   function automatic ivec_t rnd_vec();
      ivec_t r;
      for (int c = 0; c < COLS; c++) r[c] = 16'($urandom);
      return r;
   endfunction

   task automatic drain(input int budget);
      int t;
      t = 0;
      out_rdy = 1'b1;
      while ((expq.size() != 0 || out_vld) && t < budget) begin
         idle(1);
         t++;
      end
      chk("drain_left", 128'(expq.size()), 0);
      out_rdy = 1'b0;
   endtask

   task automatic do_reset();
      rst_n   = 1'b0;
      psu_vld = 1'b0;
      psu_in  = '0;
      out_rdy = 1'b0;
      w_rdy   = 1'b0;
      for (int k = 0; k < COLS; k++) hist[k] = '0;
      expq.delete();
      g_cnt = 0;
      #1;
      chk("rst_out_vld", out_vld, 0);
      chk("rst_stall", stall_req, 0);
      chk("rst_ovf", ovf_err, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_w", {w_vld, w_stall, w_ovf}, 0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   always @(negedge clk) begin
      if (rst_n && out_vld && out_rdy) begin
         n_pop++;
         if (expq.size() == 0) begin
            chk("spurious_out", 1, 0);
         end else begin
            mon_e = expq.pop_front();
            chk("out_data", out_data, mon_e);
         end
      end
   end

   initial begin
      ivec_t v;
      int    issued;
      int    pops0;
      bit    seen;
      bit    prev;
      bit    s;

      do_reset();

      // Deskew and len=1 latency.
      acc_len = 8'd1;
      for (int c = 0; c < COLS; c++) v[c] = 16'h10 + 16'(c);
      drive(1'b1, v);
      idle(3);
      chk("t1_lat4", out_vld, 0);
      idle(1);
      chk("t1_lat5", out_vld, 1);
      chk("t1_data", out_data, {24'h13, 24'h12, 24'h11, 24'h10});
      drain(20);

      // Group of three.
      acc_len = 8'd3;
      drive(1'b1, {4{16'hFFFF}});
      drive(1'b1, {4{16'h0002}});
      acc_len = 8'd1;
      idle(8);
      chk("t2_no_early", out_vld, 0);
      drive(1'b1, {4{16'h0005}});
      idle(4);
      chk("t2_vld", out_vld, 1);
      chk("t2_sum", out_data, {4{24'h6}});
      drain(20);

      // Back-pressure with stall honoured one cycle late.
      do_reset();
      acc_len = 8'd1;
      issued = 0;
      seen = 1'b0;
      prev = 1'b0;
      for (int i = 0; i < 40; i++) begin
         s = stall_req;
         if (s) seen = 1'b1;
         if (!prev) begin
            drive(1'b1, rnd_vec());
            issued++;
         end else begin
            idle(1);
         end
         prev = s;
      end
      chk("t3_stall_seen", seen, 1);
      chk("t3_issued", 128'(issued), 8);
      chk("t3_no_ovf", ovf_err, 0);
      pops0 = n_pop;
      drain(40);
      chk("t3_pops", 128'(n_pop - pops0), 8);

      // Overflow drop.
      do_reset();
      acc_len = 8'd1;
      repeat (9) drive(1'b1, rnd_vec());
      idle(3);
      chk("t4_ovf_before", ovf_err, 0);
      idle(1);
      chk("t4_ovf_after", ovf_err, 1);
      void'(expq.pop_back());
      drain(40);
      chk("t4_ovf_sticky", ovf_err, 1);

      // Full FIFO, push and pop on the same edge.
      do_reset();
      acc_len = 8'd1;
      repeat (8) drive(1'b1, rnd_vec());
      idle(6);
      chk("t5_full_vld", out_vld, 1);
      drive(1'b1, rnd_vec());
      idle(3);
      out_rdy = 1'b1;
      idle(1);
      out_rdy = 1'b0;
      idle(2);
      chk("t5_no_ovf", ovf_err, 0);
      pops0 = n_pop;
      drain(40);
      chk("t5_count", 128'(n_pop - pops0), 8);

      // Wrap versus saturation on the 16-bit instance.
      do_reset();
      out_rdy = 1'b1;
      acc_len = 8'd2;
      drive(1'b1, {4{16'h7FFF}});
      drive(1'b1, {4{16'h7FFF}});
      idle(5);
      chk("t6_w_vld", w_vld, 1);
`ifdef DSP_SYS_COLLECT_SAT_EN
      chk("t6_w_sum", w_data, {4{16'h7FFF}});
`else
      chk("t6_w_sum", w_data, {4{16'hFFFE}});
`endif
      drain(20);

      do_reset();
      out_rdy = 1'b1;
      acc_len = 8'd3;
      drive(1'b1, {4{16'h7FFF}});
      drive(1'b1, {4{16'h7FFF}});
      drive(1'b1, {4{16'h8000}});
      idle(5);
      chk("t6_w3_vld", w_vld, 1);
`ifdef DSP_SYS_COLLECT_SAT_EN
      chk("t6_w3_sum", w_data, {4{16'h7FFF}});
`else
      chk("t6_w3_sum", w_data, {4{16'h7FFE}});
`endif
      drain(20);

      // Reset in the middle of a group.
      do_reset();
      acc_len = 8'd2;
      drive(1'b1, {4{16'h7FFF}});
      idle(2);
      do_reset();
      out_rdy = 1'b1;
      acc_len = 8'd2;
      drive(1'b1, {4{16'h0001}});
      drive(1'b1, {4{16'h0002}});
      idle(5);
      chk("t6_fresh_vld", w_vld, 1);
      chk("t6_fresh_sum", w_data, {4{16'h0003}});
      drain(20);

      // Random traffic.
      do_reset();
      for (int i = 0; i < 400; i++) begin
         acc_len = 8'($urandom_range(0, 3));
         out_rdy = 1'($urandom_range(0, 1));
         if (!stall_req && $urandom_range(0, 3) != 0) drive(1'b1, rnd_vec());
         else idle(1);
      end
      idle(COLS + 2);
      drain(200);
      chk("t7_no_ovf", ovf_err, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
